// File: rtl/dom_and_pipelined.sv
// rtl/dom_and_pipelined.sv - parametrised pipelined DOM AND gadget with valid/ready flow control
module dom_and_pipelined #(
    parameter int ORDER   = 1,
    parameter int WIDTH   = 8,
    parameter int OUT_REG = 0
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    valid_i,
    output logic                                    ready_o,
    input  logic [(ORDER+1)*WIDTH-1:0]              x_i,
    input  logic [(ORDER+1)*WIDTH-1:0]              y_i,
    input  logic [(ORDER*(ORDER+1)/2)*WIDTH-1:0]    z_i,
    output logic                                    valid_o,
    input  logic                                    ready_i,
    output logic [(ORDER+1)*WIDTH-1:0]              q_o
);

    localparam int NS = ORDER + 1;
    localparam int NR = ORDER * (ORDER + 1) / 2;

    if (ORDER < 1) begin : g_bad_order
        $error("dom_and_pipelined: ORDER must be at least 1");
    end

    // Index of the fresh random word shared by domains a and b (any order).
    // Pairs are numbered lexicographically: (0,1),(0,2)..(0,d),(1,2),...
    function automatic int pair_idx(input int a, input int b);
        int lo;
        int hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        return lo * NS - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

    // term[i][j] (i != j) is the remasked cross product X_i & Y_j ^ Z_k;
    // term[i][i] holds the inner product X_i & Y_i so it moves with the
    // cross terms through the same enable and stays aligned under stall.
    logic [WIDTH-1:0]    term_d [NS][NS];
    logic [WIDTH-1:0]    term_q [NS][NS];
    logic [WIDTH-1:0]    share_c [NS];
    logic [NS*WIDTH-1:0] share_flat;

    logic v1_q;
    logic v1_d;
    logic accept;
    logic ready_next;

    assign ready_o = !v1_q || ready_next;
    assign accept  = valid_i && ready_o;

    // Per-domain products and remasking; no cross-domain XOR of unmasked data here.
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < NS; j++) begin
                if (i == j) begin
                    term_d[i][j] = x_i[i*WIDTH +: WIDTH] & y_i[i*WIDTH +: WIDTH];
                end else begin
                    term_d[i][j] = (x_i[i*WIDTH +: WIDTH] & y_i[j*WIDTH +: WIDTH])
                                 ^ z_i[pair_idx(i, j)*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Resharing register: loads only on accept, otherwise holds without toggling.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NS; i++) begin
                for (int j = 0; j < NS; j++) begin
                    term_q[i][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < NS; i++) begin
                for (int j = 0; j < NS; j++) begin
                    term_q[i][j] <= term_d[i][j];
                end
            end
        end
    end

    // Stage 1 stays full on a new accept, empties when drained without one.
    always_comb begin
        v1_d = accept || (v1_q && !ready_next);
    end

    // Stage 1 valid flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
        end
    end

    // Compression: each output share only combines registers of its own domain.
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            share_c[i] = term_q[i][i];
            for (int j = 0; j < NS; j++) begin
                if (j != i) begin
                    share_c[i] = share_c[i] ^ term_q[i][j];
                end
            end
        end
    end

    for (genvar s = 0; s < NS; s++) begin : g_pack
        assign share_flat[s*WIDTH +: WIDTH] = share_c[s];
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                v2_q;
        logic                v2_d;
        logic                load2;
        logic [NS*WIDTH-1:0] q2_q;

        assign ready_next = !v2_q || ready_i;
        assign load2      = v1_q && ready_next;

        // Stage 2 refills on the same cycle it drains, so no bubble is inserted.
        always_comb begin
            v2_d = load2 || (v2_q && !ready_i);
        end

        // Output register and its valid flag; data only moves on load.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v2_q <= 1'b0;
                q2_q <= '0;
            end else begin
                v2_q <= v2_d;
                if (load2) begin
                    q2_q <= share_flat;
                end
            end
        end

        assign valid_o = v2_q;
        assign q_o     = q2_q;
    end else begin : g_out_comb
        assign ready_next = ready_i;
        assign valid_o    = v1_q;
        assign q_o        = share_flat;
    end

endmodule

// File: doc/dom_and_pipelined.md
Name: dom_and_pipelined

Overview:
- Parametrised Domain-Oriented Masking (DOM) AND gadget, the successor to the fixed 1st/2nd/3rd-order DOM AND gadgets.
- Arbitrary masking order, data width and output registering.
- Elastic valid/ready pipeline with stall support, so share inputs need not be held stable after acceptance.
- Building block for masked S-box and datapath cores. It is instantiated wherever a shared nonlinear AND is needed under backpressure.

Parameters:
- ORDER, 1, masking order d; share count NS = ORDER+1; ORDER<1 is an elaboration error.
- WIDTH, 8, bits per share.
- OUT_REG, 0, 1 adds a registered output stage, so latency is 2 instead of 1.
- Derived (localparam): NR = ORDER*(ORDER+1)/2, the number of fresh random words per operation.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  input operands and randomness are valid.
- ready_o  out  1  gadget accepts the input this cycle.
- x_i  in  NS*WIDTH  X shares; share s is at bits [s*WIDTH +: WIDTH].
- y_i  in  NS*WIDTH  Y shares, same packing as x_i.
- z_i  in  NR*WIDTH  fresh randomness; word k is at bits [k*WIDTH +: WIDTH].
- valid_o  out  1  output shares are valid.
- ready_i  in  1  downstream accepts the output.
- q_o  out  NS*WIDTH  output shares of X&Y, same packing as x_i.

Behaviour:
- Reset:
  - Asserting rst_ni=0 asynchronously clears all data registers to 0 and all valid flags to 0.
  - After reset: valid_o=0, q_o=0, and ready_o=1 once reset is released.
- Pair/randomness mapping:
  - Unordered domain pairs (i,j), i<j, are enumerated lexicographically: (0,1),(0,2),…,(0,d),(1,2),… gives k=0..NR-1.
  - Both cross terms X_i&Y_j and X_j&Y_i use z word k.
- Stage 1 (resharing register), loaded only on accept (valid_i & ready_o):
  - Cross registers c[i][j] <= (X_i & Y_j) ^ Z_k(i,j) for all i≠j.
  - Inner registers n[i] <= X_i & Y_i. Inner terms are registered alongside the cross terms so they stay aligned under stall.
  - No XOR across domains may occur before the c registers.
- Stage 1 hold and flow control:
  - The stage holds when it is not loading. Registers do not toggle on bubbles or stalls.
  - v1 is the valid flag of stage 1; it sets on accept and clears when stage 1 drains without a new accept.
  - ready_o = !v1 | ready_next, where ready_next = ready_i (OUT_REG=0) or !v2 | ready_i (OUT_REG=1).
- Compression:
  - q_share[i] = n[i] ^ XOR over j≠i of c[i][j].
  - Only registers of domain i are combined, and only after the stage 1 registers.
- OUT_REG=0:
  - q_o is driven by the compression logic; valid_o = v1.
  - Latency is 1 cycle from accept to valid_o.
- OUT_REG=1:
  - A stage 2 register captures q_share when v1 & (!v2 | ready_i); v2 is its valid flag.
  - q_o is the register output; valid_o = v2. Latency is 2 cycles.
- Throughput: one operation per cycle when ready_i=1 continuously. No bubbles are inserted.
- Stall:
  - While valid_o=1 and ready_i=0, q_o and valid_o hold stable.
  - Upstream is stalled once all stages are full.
  - Input changes while ready_o=0 do not affect any register.
- Simultaneous accept and drain on the same stage: the new data is loaded, the valid flag stays 1, and no data is lost or duplicated.
- Correctness invariant: the XOR of all q_o shares equals (XOR of x shares) & (XOR of y shares), bitwise for all WIDTH bits, for any z.
- Reset mid-operation: in-flight data is discarded and no valid_o pulse follows. The next accept behaves as the first one after reset.

Test Plan:
- ORDER=1, WIDTH=8, OUT_REG=0: x shares {0x3C,0x99}, y shares {0x55,0x5A}, z=0x77, one valid_i pulse, ready_i=1 → next cycle valid_o=1, q_o shares {0x7B,0x7E}, XOR=0x05.
- ORDER=2, WIDTH=8: 1000 random operands and random z, valid_i=1, ready_i=1 → valid_o each cycle after 1-cycle latency; XOR of 3 shares = x&y for every result; order preserved.
- ORDER=3, OUT_REG=1: back-to-back stream with ready_i toggling randomly (about 50%) → no loss or duplication; q_o stable while valid_o & !ready_i; ready_o=0 only when both stages are full; latency 2.
- Stall isolation: fill the pipeline with ready_i=0, then drive random garbage on x_i/y_i/z_i for 10 cycles → q_o and all internal registers unchanged.
- Reset mid-stream: rst_ni=0 asynchronously between clock edges while valid_o=1 → valid_o=0 and q_o=0 immediately; after release, the first accepted operation produces the correct result with nominal latency.
- Randomness mapping, ORDER=2, x=y=0: z words {0x01,0x02,0x04} → q_o shares {0x03,0x05,0x06}.
